// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and sequencing controller for a 5-stage pipe,
//   built around the ID/EX register. Latency: all controls are combinational
//   (Mealy on state + inputs); the state, wait counter and Stall_Count are registered.
// Backpressure: a data-memory wait freezes everything (Pipe_Hold plus the PC/IF-ID
//   holds). A load-use (or RAW) stall holds PC/IF-ID and injects one ID/EX bubble.
//
// Ports:
//   CLK, CLR                  clock (rising edge); asynchronous active-high reset
//   ID_Rn/ID_Rm/ID_Rc         ID-stage source registers for ports A/B/C
//   ID_UseA/ID_UseB/ID_UseC   the matching source is actually read
//   EX_Rd/EX_rf/EX_Load       EX-stage destination, writes RF, is a load
//   MEM_Rd/MEM_rf             MEM-stage destination, writes RF
//   WB_Rd/WB_rf               WB-stage destination, writes RF
//   MEM_Enable/Mem_Ready      data-memory access in MEM; memory done this cycle
//   Branch_Taken              branch resolved taken in EX
//   PC_LE/IFID_LE             load enables (0 = hold)
//   IFID_CLR/IDEX_CLR         inject a bubble into IF/ID or ID/EX
//   Pipe_Hold                 freeze the EX/MEM and MEM/WB registers
//   Fwd_A/Fwd_B/Fwd_C         operand source: 00 RF, 01 EX, 10 MEM, 11 WB
//   Mem_Err                   one-cycle pulse when a memory wait times out
//   Stall_Count               saturating count of stalled or bubbled cycles
//
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding.
//   With the macro defined, only load-use hazards stall.
//   Without it, the Fwd outputs are tied to 00 and any RAW hazard against
//   EX, MEM or WB stalls until the producer has written the register file.

module pipeline_hazard_ctrl #(
  parameter int WAIT_MAX = 16,  // memory-wait cycles allowed before Mem_Err (1..255)
  parameter int CNT_W    = 16   // width of Stall_Count
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [3:0]       ID_Rn,
  input  logic [3:0]       ID_Rm,
  input  logic [3:0]       ID_Rc,
  input  logic             ID_UseA,
  input  logic             ID_UseB,
  input  logic             ID_UseC,
  input  logic [3:0]       EX_Rd,
  input  logic             EX_rf,
  input  logic             EX_Load,
  input  logic [3:0]       MEM_Rd,
  input  logic             MEM_rf,
  input  logic [3:0]       WB_Rd,
  input  logic             WB_rf,
  input  logic             MEM_Enable,
  input  logic             Mem_Ready,
  input  logic             Branch_Taken,
  output logic             PC_LE,
  output logic             IFID_LE,
  output logic             IFID_CLR,
  output logic             IDEX_CLR,
  output logic             Pipe_Hold,
  output logic [1:0]       Fwd_A,
  output logic [1:0]       Fwd_B,
  output logic [1:0]       Fwd_C,
  output logic             Mem_Err,
  output logic [CNT_W-1:0] Stall_Count
);

  // FSM encoding
  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_BR_FLUSH = 2'd2;

  localparam logic [8:0]       WAIT_LIM = 9'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic [8:0] wait_inc;

  // Source/destination matches, per port and per producing stage.
  logic a_ex, a_mem, a_wb;
  logic b_ex, b_mem, b_wb;
  logic c_ex, c_mem, c_wb;

  logic mem_stall;
  logic load_use;
  logic raw_stall;
  logic stall_cyc;

  assign a_ex  = ID_UseA & EX_rf  & (ID_Rn == EX_Rd);
  assign a_mem = ID_UseA & MEM_rf & (ID_Rn == MEM_Rd);
  assign a_wb  = ID_UseA & WB_rf  & (ID_Rn == WB_Rd);
  assign b_ex  = ID_UseB & EX_rf  & (ID_Rm == EX_Rd);
  assign b_mem = ID_UseB & MEM_rf & (ID_Rm == MEM_Rd);
  assign b_wb  = ID_UseB & WB_rf  & (ID_Rm == WB_Rd);
  assign c_ex  = ID_UseC & EX_rf  & (ID_Rc == EX_Rd);
  assign c_mem = ID_UseC & MEM_rf & (ID_Rc == MEM_Rd);
  assign c_wb  = ID_UseC & WB_rf  & (ID_Rc == WB_Rd);

  assign mem_stall = MEM_Enable & ~Mem_Ready;
  assign load_use  = EX_Load & (a_ex | b_ex | c_ex);

`ifdef HAZARD_FORWARDING_EN
  // Youngest producer wins. A load in EX has no data yet, so an EX hit on a
  // load is never forwarded; the load-use stall covers that case.
  function automatic logic [1:0] fwd_sel(input logic ex_hit,
                                         input logic mem_hit,
                                         input logic wb_hit);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_hit)       sel = 2'b01;
    else if (mem_hit) sel = 2'b10;
    else if (wb_hit)  sel = 2'b11;
    return sel;
  endfunction

  assign raw_stall = load_use;
  assign Fwd_A     = fwd_sel(a_ex & ~EX_Load, a_mem, a_wb);
  assign Fwd_B     = fwd_sel(b_ex & ~EX_Load, b_mem, b_wb);
  assign Fwd_C     = fwd_sel(c_ex & ~EX_Load, c_mem, c_wb);
`else
  // No bypass network: any pending write to a source must reach the RF first.
  // WB is included because the RF is written at the same clock edge.
  assign raw_stall = load_use
                   | a_ex | a_mem | a_wb
                   | b_ex | b_mem | b_wb
                   | c_ex | c_mem | c_wb;
  assign Fwd_A     = 2'b00;
  assign Fwd_B     = 2'b00;
  assign Fwd_C     = 2'b00;
`endif

  // The held cycle that enters MEM_WAIT counts as wait cycle 1, so the
  // timeout check looks at the post-increment value.
  assign wait_inc = {1'b0, wait_cnt} + 9'd1;

  always_comb begin
    PC_LE        = 1'b1;
    IFID_LE      = 1'b1;
    IFID_CLR     = 1'b0;
    IDEX_CLR     = 1'b0;
    Pipe_Hold    = 1'b0;
    Mem_Err      = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;

    case (state)
      S_RUN: begin
        if (mem_stall) begin
          Pipe_Hold    = 1'b1;
          PC_LE        = 1'b0;
          IFID_LE      = 1'b0;
          state_nxt    = S_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else if (Branch_Taken) begin
          // Flush both wrong-path instructions; PC keeps loading the target.
          IFID_CLR  = 1'b1;
          IDEX_CLR  = 1'b1;
          state_nxt = S_BR_FLUSH;
        end else if (raw_stall) begin
          PC_LE    = 1'b0;
          IFID_LE  = 1'b0;
          IDEX_CLR = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        // Everything stays frozen, including the cycle the memory completes.
        Pipe_Hold = 1'b1;
        PC_LE     = 1'b0;
        IFID_LE   = 1'b0;
        if (Mem_Ready) begin
          state_nxt    = S_RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_inc >= WAIT_LIM) begin
          Mem_Err      = 1'b1;
          state_nxt    = S_RUN;
          wait_cnt_nxt = 8'd0;
        end else begin
          wait_cnt_nxt = wait_inc[7:0];
        end
      end

      S_BR_FLUSH: begin
        // ID holds the bubble from the flush, so its hazards are meaningless.
        if (mem_stall) begin
          Pipe_Hold    = 1'b1;
          PC_LE        = 1'b0;
          IFID_LE      = 1'b0;
          state_nxt    = S_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else begin
          state_nxt = S_RUN;
        end
      end

      default: begin
        state_nxt    = S_RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign stall_cyc = ~PC_LE | IDEX_CLR;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= S_RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      Stall_Count <= {CNT_W{1'b0}};
    end else if (stall_cyc && (Stall_Count != CNT_MAX)) begin
      Stall_Count <= Stall_Count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench for pipeline_hazard_ctrl.
//   A table of one-cycle vectors runs first, followed by hand-written multi-cycle sequences.
//   Expected values are hand-derived; Stall_Count follows a saturating model of expected stalls.

module tb_pipeline_hazard_ctrl;

  localparam int TB_WAIT = 4;
  localparam int TB_CW   = 6;
  localparam int CMAX    = (1 << TB_CW) - 1;

  // {PC_LE, IFID_LE, IFID_CLR, IDEX_CLR, Pipe_Hold}
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_HOLD  = 5'b00001;
  localparam logic [4:0] C_BR    = 5'b11110;
  localparam logic [5:0] F0      = 6'b000000;

`ifdef HAZARD_FORWARDING_EN
  localparam logic [4:0] C_RAW  = C_RUN;
  localparam logic [5:0] FA_MEM = 6'b100000;
  localparam logic [5:0] FB_EX  = 6'b000100;
  localparam logic [5:0] FB_MEM = 6'b001000;
  localparam logic [5:0] FB_WB  = 6'b001100;
  localparam logic [5:0] FC_EX  = 6'b000001;
  localparam logic [5:0] FC_MEM = 6'b000010;
  localparam logic [5:0] FC_WB  = 6'b000011;
`else
  localparam logic [4:0] C_RAW  = C_STALL;
  localparam logic [5:0] FA_MEM = F0;
  localparam logic [5:0] FB_EX  = F0;
  localparam logic [5:0] FB_MEM = F0;
  localparam logic [5:0] FB_WB  = F0;
  localparam logic [5:0] FC_EX  = F0;
  localparam logic [5:0] FC_MEM = F0;
  localparam logic [5:0] FC_WB  = F0;
`endif

  typedef struct packed {
    logic [3:0] rn, rm, rc;
    logic [2:0] usep;        // {UseA, UseB, UseC}
    logic [3:0] exd;
    logic       exrf, exld;
    logic [3:0] memd;
    logic       memrf;
    logic [3:0] wbd;
    logic       wbrf;
    logic       men, mrdy, br;
    logic [4:0] ctl;
    logic [5:0] fwd;         // {Fwd_A, Fwd_B, Fwd_C}
    logic       err;
  } vec_t;

  logic             CLK = 1'b0;
  logic             CLR;
  logic [3:0]       ID_Rn, ID_Rm, ID_Rc;
  logic             ID_UseA, ID_UseB, ID_UseC;
  logic [3:0]       EX_Rd, MEM_Rd, WB_Rd;
  logic             EX_rf, EX_Load, MEM_rf, WB_rf;
  logic             MEM_Enable, Mem_Ready, Branch_Taken;
  logic             PC_LE, IFID_LE, IFID_CLR, IDEX_CLR, Pipe_Hold, Mem_Err;
  logic [1:0]       Fwd_A, Fwd_B, Fwd_C;
  logic [TB_CW-1:0] Stall_Count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.WAIT_MAX(TB_WAIT), .CNT_W(TB_CW)) dut (
    .CLK(CLK), .CLR(CLR),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rc(ID_Rc),
    .ID_UseA(ID_UseA), .ID_UseB(ID_UseB), .ID_UseC(ID_UseC),
    .EX_Rd(EX_Rd), .EX_rf(EX_rf), .EX_Load(EX_Load),
    .MEM_Rd(MEM_Rd), .MEM_rf(MEM_rf),
    .WB_Rd(WB_Rd), .WB_rf(WB_rf),
    .MEM_Enable(MEM_Enable), .Mem_Ready(Mem_Ready), .Branch_Taken(Branch_Taken),
    .PC_LE(PC_LE), .IFID_LE(IFID_LE), .IFID_CLR(IFID_CLR), .IDEX_CLR(IDEX_CLR),
    .Pipe_Hold(Pipe_Hold),
    .Fwd_A(Fwd_A), .Fwd_B(Fwd_B), .Fwd_C(Fwd_C),
    .Mem_Err(Mem_Err), .Stall_Count(Stall_Count)
  );

  function automatic vec_t mk(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rc,
                              input logic [2:0] u,
                              input logic [3:0] exd, input logic exrf, input logic exld,
                              input logic [3:0] memd, input logic memrf,
                              input logic [3:0] wbd, input logic wbrf,
                              input logic men, input logic mrdy, input logic br,
                              input logic [4:0] ctl, input logic [5:0] fwd, input logic err);
    vec_t v;
    v.rn = rn; v.rm = rm; v.rc = rc; v.usep = u;
    v.exd = exd; v.exrf = exrf; v.exld = exld;
    v.memd = memd; v.memrf = memrf; v.wbd = wbd; v.wbrf = wbrf;
    v.men = men; v.mrdy = mrdy; v.br = br;
    v.ctl = ctl; v.fwd = fwd; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    ID_Rn = v.rn; ID_Rm = v.rm; ID_Rc = v.rc;
    {ID_UseA, ID_UseB, ID_UseC} = v.usep;
    EX_Rd = v.exd; EX_rf = v.exrf; EX_Load = v.exld;
    MEM_Rd = v.memd; MEM_rf = v.memrf;
    WB_Rd = v.wbd; WB_rf = v.wbrf;
    MEM_Enable = v.men; Mem_Ready = v.mrdy; Branch_Taken = v.br;
  endtask

  // One clock cycle: drive just after the edge, check at the falling edge.
  task automatic step(input vec_t v, input string nm);
    drive(v);
    @(negedge CLK);
    chk({nm, "/ctl"}, 32'({PC_LE, IFID_LE, IFID_CLR, IDEX_CLR, Pipe_Hold}), 32'(v.ctl));
    chk({nm, "/fwd"}, 32'({Fwd_A, Fwd_B, Fwd_C}), 32'(v.fwd));
    chk({nm, "/err"}, 32'(Mem_Err), 32'(v.err));
    chk({nm, "/cnt"}, 32'(Stall_Count), 32'(exp_cnt));
    if ((!v.ctl[4] || v.ctl[1]) && exp_cnt != CMAX) exp_cnt++;
    @(posedge CLK);
    #1;
  endtask

  vec_t tbl [0:23];
  vec_t idle, lu, w0, w1, v;
  int   c0;

  initial begin
    idle = mk(4'd1, 4'd2, 4'd3, 3'b000, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0,
              1'b0, 1'b0, 1'b0, C_RUN, F0, 1'b0);
    lu   = mk(4'd3, 4'd2, 4'd1, 3'b100, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0,
              1'b0, 1'b0, 1'b0, C_STALL, F0, 1'b0);
    w0   = mk(4'd1, 4'd2, 4'd3, 3'b000, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0,
              1'b1, 1'b0, 1'b0, C_HOLD, F0, 1'b0);
    w1   = w0; w1.mrdy = 1'b1;

    tbl[0]  = idle;
    tbl[1]  = lu;                                                      // load-use bubble
    tbl[2]  = mk(4'd3, 4'd2, 4'd1, 3'b100, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0,
                 1'b0, 1'b0, 1'b0, C_RAW, FA_MEM, 1'b0);               // load now in MEM
    tbl[3]  = mk(4'd1, 4'd5, 4'd2, 3'b010, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 4'd5, 1'b1,
                 1'b0, 1'b0, 1'b0, C_RAW, FB_EX, 1'b0);                // EX beats MEM/WB
    tbl[4]  = tbl[3]; tbl[4].exrf = 1'b0; tbl[4].fwd = FB_MEM;
    tbl[5]  = tbl[4]; tbl[5].memrf = 1'b0; tbl[5].fwd = FB_WB;
    tbl[6]  = mk(4'd4, 4'd2, 4'd1, 3'b000, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0,
                 1'b0, 1'b0, 1'b0, C_RUN, F0, 1'b0);                   // match but not used
    tbl[7]  = mk(4'd1, 4'd2, 4'd15, 3'b001, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0,
                 1'b0, 1'b0, 1'b0, C_RAW, FC_EX, 1'b0);                // R15 is ordinary
    tbl[8]  = idle;
    tbl[9]  = lu; tbl[9].br = 1'b1; tbl[9].ctl = C_BR;                 // branch beats load-use
    tbl[10] = tbl[9]; tbl[10].ctl = C_RUN;                             // BR_FLUSH ignores both
    tbl[11] = lu;                                                      // back in RUN
    tbl[12] = idle;
    tbl[13] = mk(4'd1, 4'd7, 4'd2, 3'b010, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0,
                 1'b1, 1'b0, 1'b1, C_HOLD, FB_MEM, 1'b0);              // mem wait beats branch
    tbl[14] = tbl[13]; tbl[14].mrdy = 1'b1;                            // release cycle still held
    tbl[15] = lu;                                                      // RUN, not BR_FLUSH
    tbl[16] = idle;
    tbl[17] = tbl[9];
    tbl[18] = w0;                                                      // BR_FLUSH honours mem wait
    tbl[19] = w1;                                                      // held: proves MEM_WAIT
    tbl[20] = idle;
    tbl[21] = mk(4'd1, 4'd2, 4'd2, 3'b001, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0,
                 1'b0, 1'b0, 1'b0, C_RAW, FC_MEM, 1'b0);               // producer in MEM
    tbl[22] = mk(4'd1, 4'd2, 4'd2, 3'b001, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1,
                 1'b0, 1'b0, 1'b0, C_RAW, FC_WB, 1'b0);                // producer in WB
    tbl[23] = mk(4'd1, 4'd2, 4'd2, 3'b001, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0,
                 1'b0, 1'b0, 1'b0, C_RUN, F0, 1'b0);                   // producer gone

    // Reset state
    CLR = 1'b1;
    drive(idle);
    #3;
    chk("rst/ctl", 32'({PC_LE, IFID_LE, IFID_CLR, IDEX_CLR, Pipe_Hold}), 32'(C_RUN));
    chk("rst/fwd", 32'({Fwd_A, Fwd_B, Fwd_C}), 32'(F0));
    chk("rst/err", 32'(Mem_Err), 32'd0);
    chk("rst/cnt", 32'(Stall_Count), 32'd0);
    #9 CLR = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 24; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Memory wait: three not-ready cycles, then ready -> four held cycles
    c0 = exp_cnt;
    for (int i = 0; i < 3; i++) step(w0, $sformatf("wait%0d", i));
    step(w1, "wait_rdy");
    step(idle, "wait_after");
    chk("wait/cnt+4", 32'(Stall_Count), 32'(c0 + 4));

    // Timeout: error pulse on the fourth held cycle, RUN afterwards
    for (int i = 0; i < 3; i++) step(w0, $sformatf("tmo%0d", i));
    v = w0; v.err = 1'b1;
    step(v, "tmo_err");
    step(idle, "tmo_after");

    // Asynchronous reset in the middle of a wait
    step(w0, "clr_enter");
    drive(w0);
    #2 CLR = 1'b1;
    #1;
    chk("clr/cnt", 32'(Stall_Count), 32'd0);
    chk("clr/err", 32'(Mem_Err), 32'd0);
    drive(idle);
    #1;
    chk("clr/ctl", 32'({PC_LE, IFID_LE, IFID_CLR, IDEX_CLR, Pipe_Hold}), 32'(C_RUN));
    exp_cnt = 0;
    @(negedge CLK);
    CLR = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) step(w0, $sformatf("tmo2_%0d", i));
    step(v, "tmo2_err");
    step(idle, "tmo2_after");

    // Stall counter saturation
    for (int i = 0; i < 70; i++) step(lu, $sformatf("sat%0d", i));
    step(idle, "sat_end");
    chk("sat/cnt", 32'(Stall_Count), 32'(CMAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
